rat_search_engine: RTL and testbench

Parametrised depth-first maze solver for the rat-in-maze lab. It is the successor to the fixed 4-direction controller. Grid size, stack depth and move set (4- or 8-neighbour) are parameters. The stack is internal, and the solved path is streamed out through a valid/ready port. The maze sits in an external single-port bit memory: 1 = wall or visited, 0 = free.

---
 rtl/rat_search_engine_if.sv | 31 +++
 rtl/rat_search_engine.sv | 245 ++++++++++++++++++++++++
 tb/tb_rat_search_engine.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rat_search_engine_if.sv
// Memory bus and solved-path stream of the rat-in-maze search engine.
// The engine connects as master; the maze memory and path sink connect as slave.
interface rat_search_engine_if #(
    parameter int RW = 3,
    parameter int CW = 3,
    parameter int LW = 7
);
    logic [RW+CW-1:0] mem_addr;
    logic             mem_rd;
    logic             mem_rdata;
    logic             mem_wr;
    logic             mem_wdata;
    logic             path_valid;
    logic             path_ready;
    logic [RW-1:0]    path_row;
    logic [CW-1:0]    path_col;
    logic             path_last;
    logic [LW-1:0]    path_len;

    modport master (
        output mem_addr, mem_rd, mem_wr, mem_wdata,
        output path_valid, path_row, path_col, path_last, path_len,
        input  mem_rdata, path_ready
    );

    modport slave (
        input  mem_addr, mem_rd, mem_wr, mem_wdata,
        input  path_valid, path_row, path_col, path_last, path_len,
        output mem_rdata, path_ready
    );
endinterface

// File: rtl/rat_search_engine.sv
// Depth-first maze solver with an internal backtrack stack; the solved path
// (start to goal) is streamed out once the goal cell has been marked.
module rat_search_engine #(
    parameter int ROWS        = 8,
    parameter int COLS        = 8,
    parameter int STACK_DEPTH = 64,
    parameter int DIAG        = 0,
    parameter int RW          = $clog2(ROWS),
    parameter int CW          = $clog2(COLS)
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic done,
    output logic fail,
    output logic ovf,
    rat_search_engine_if.master bus
);
    localparam int NDIR = (DIAG != 0) ? 8 : 4;
    localparam int DW   = $clog2(NDIR) + 1;
    localparam int SPW  = $clog2(STACK_DEPTH + 1);
    localparam int LW   = $clog2(STACK_DEPTH + 2);

    localparam logic [RW-1:0]  ROW_MAX = RW'(ROWS - 1);
    localparam logic [CW-1:0]  COL_MAX = CW'(COLS - 1);
    localparam logic [DW-1:0]  DIR_END = DW'(NDIR);
    localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);

    typedef enum logic [3:0] {
        S_IDLE, S_RD0, S_CHK0, S_MARK, S_NEXT, S_EVAL, S_BACK, S_OUT, S_DONE, S_FAIL
    } state_t;

    typedef struct packed {
        logic [RW-1:0] row;
        logic [CW-1:0] col;
        logic [DW-1:0] dir;
    } entry_t;

    state_t         state;
    logic [RW-1:0]  pos_row;
    logic [CW-1:0]  pos_col;
    logic [DW-1:0]  dir;
    logic [SPW-1:0] sp;
    logic [SPW-1:0] idx;
    logic [LW-1:0]  len;

    // One spare entry keeps the index width exact; it is read (never written)
    // only when the stream reaches the goal beat on a full stack.
    entry_t stack [0:STACK_DEPTH];

    logic [RW-1:0]  nb_row;
    logic [CW-1:0]  nb_col;
    logic           nb_oob;
    logic [SPW-1:0] sp_dec;
    logic           at_goal;
    logic           out_last;
    logic           push;

    assign sp_dec   = sp - SPW'(1);
    assign at_goal  = (pos_row == ROW_MAX) && (pos_col == COL_MAX);
    assign out_last = (idx == sp);
    assign push     = (state == S_EVAL) && !bus.mem_rdata && (sp != SP_FULL);

    // Bounds are tested before stepping, so a wrapped coordinate is never used.
    always_comb begin
        nb_row = pos_row;
        nb_col = pos_col;
        nb_oob = 1'b0;
        case (dir)
            DW'(0): begin nb_oob = (pos_col == COL_MAX); nb_col = pos_col + CW'(1); end
            DW'(1): begin nb_oob = (pos_row == ROW_MAX); nb_row = pos_row + RW'(1); end
            DW'(2): begin nb_oob = (pos_col == '0);      nb_col = pos_col - CW'(1); end
            DW'(3): begin nb_oob = (pos_row == '0);      nb_row = pos_row - RW'(1); end
            DW'(4): begin
                nb_oob = (pos_row == ROW_MAX) || (pos_col == COL_MAX);
                nb_row = pos_row + RW'(1);
                nb_col = pos_col + CW'(1);
            end
            DW'(5): begin
                nb_oob = (pos_row == ROW_MAX) || (pos_col == '0);
                nb_row = pos_row + RW'(1);
                nb_col = pos_col - CW'(1);
            end
            DW'(6): begin
                nb_oob = (pos_row == '0) || (pos_col == '0);
                nb_row = pos_row - RW'(1);
                nb_col = pos_col - CW'(1);
            end
            DW'(7): begin
                nb_oob = (pos_row == '0) || (pos_col == COL_MAX);
                nb_row = pos_row - RW'(1);
                nb_col = pos_col + CW'(1);
            end
            default: nb_oob = 1'b1;
        endcase
    end

    always_comb begin
        bus.mem_rd   = 1'b0;
        bus.mem_wr   = 1'b0;
        bus.mem_addr = '0;
        case (state)
            S_RD0: begin
                bus.mem_rd   = 1'b1;
                bus.mem_addr = {pos_row, pos_col};
            end
            S_MARK: begin
                bus.mem_wr   = 1'b1;
                bus.mem_addr = {pos_row, pos_col};
            end
            S_NEXT: begin
                if (dir != DIR_END && !nb_oob) begin
                    bus.mem_rd   = 1'b1;
                    bus.mem_addr = {nb_row, nb_col};
                end
            end
            default: ;
        endcase
    end

    assign bus.mem_wdata  = bus.mem_wr;
    assign bus.path_valid = (state == S_OUT);
    assign bus.path_last  = (state == S_OUT) && out_last;
    assign bus.path_len   = len;

    always_comb begin
        bus.path_row = '0;
        bus.path_col = '0;
        if (state == S_OUT) begin
            bus.path_row = out_last ? pos_row : stack[idx].row;
            bus.path_col = out_last ? pos_col : stack[idx].col;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            stack[sp] <= '{row: pos_row, col: pos_col, dir: dir};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            pos_row <= '0;
            pos_col <= '0;
            dir     <= '0;
            sp      <= '0;
            idx     <= '0;
            len     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            fail    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (start) begin
                        state   <= S_RD0;
                        pos_row <= '0;
                        pos_col <= '0;
                        dir     <= '0;
                        sp      <= '0;
                        idx     <= '0;
                        len     <= '0;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        fail    <= 1'b0;
                        ovf     <= 1'b0;
                    end
                end
                S_RD0:  state <= S_CHK0;
                S_CHK0: begin
                    if (bus.mem_rdata) begin
                        state <= S_FAIL;
                        fail  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        state <= S_MARK;
                    end
                end
                S_MARK: begin
                    if (at_goal) begin
                        state <= S_OUT;
                        idx   <= '0;
                        len   <= LW'(sp) + LW'(1);
                    end else begin
                        state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (dir == DIR_END)
                        state <= S_BACK;
                    else if (nb_oob)
                        dir <= dir + DW'(1);
                    else
                        state <= S_EVAL;
                end
                S_EVAL: begin
                    if (!bus.mem_rdata) begin
                        if (sp == SP_FULL) begin
                            state <= S_FAIL;
                            fail  <= 1'b1;
                            ovf   <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            sp      <= sp + SPW'(1);
                            pos_row <= nb_row;
                            pos_col <= nb_col;
                            dir     <= '0;
                            state   <= S_MARK;
                        end
                    end else begin
                        dir   <= dir + DW'(1);
                        state <= S_NEXT;
                    end
                end
                S_BACK: begin
                    if (sp == '0) begin
                        state <= S_FAIL;
                        fail  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        sp      <= sp_dec;
                        pos_row <= stack[sp_dec].row;
                        pos_col <= stack[sp_dec].col;
                        dir     <= stack[sp_dec].dir + DW'(1);
                        state   <= S_NEXT;
                    end
                end
                S_OUT: begin
                    if (bus.path_ready) begin
                        if (out_last) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            idx <= idx + SPW'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rat_search_engine.sv
// Self-checking bench: table of 4x4 mazes with hand-derived paths, a scoreboard
// of expected path beats, and hand sequences for timing, backpressure and reset.
module tb_rat_search_engine;
    typedef struct packed {
        logic [1:0] row;
        logic [1:0] col;
        logic       last;
    } beat_t;

    // path: one nibble per beat, MSB first, nibble = row*4 + col
    typedef struct {
        bit          inst;
        logic [15:0] walls;
        int          n;
        logic [63:0] path;
        bit          exp_done;
        bit          exp_ovf;
        logic [15:0] exp_mem;
        int          exp_wr;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start_a, start_b;
    logic busy_a, done_a, fail_a, ovf_a;
    logic busy_b, done_b, fail_b, ovf_b;

    rat_search_engine_if #(.RW(2), .CW(2), .LW(7)) ifa ();
    rat_search_engine_if #(.RW(2), .CW(2), .LW(3)) ifb ();

    rat_search_engine #(.ROWS(4), .COLS(4), .STACK_DEPTH(64), .DIAG(0)) dut_a (
        .clk(clk), .rst(rst), .start(start_a),
        .busy(busy_a), .done(done_a), .fail(fail_a), .ovf(ovf_a), .bus(ifa)
    );

    rat_search_engine #(.ROWS(4), .COLS(4), .STACK_DEPTH(3), .DIAG(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b),
        .busy(busy_b), .done(done_b), .fail(fail_b), .ovf(ovf_b), .bus(ifb)
    );

    // maze memories with synchronous read, write-one marking and load port
    logic [15:0] mem_a, mem_b, maze_a, maze_b;
    logic        load_a, load_b;
    int          wr_a = 0, wr_b = 0, both_strobe = 0;

    always @(posedge clk) begin
        if (load_a) begin
            mem_a <= maze_a;
            wr_a  <= 0;
        end else if (ifa.mem_wr) begin
            mem_a[ifa.mem_addr] <= 1'b1;
            wr_a <= wr_a + 1;
        end
        if (ifa.mem_rd) ifa.mem_rdata <= mem_a[ifa.mem_addr];
        if (load_b) begin
            mem_b <= maze_b;
            wr_b  <= 0;
        end else if (ifb.mem_wr) begin
            mem_b[ifb.mem_addr] <= 1'b1;
            wr_b <= wr_b + 1;
        end
        if (ifb.mem_rd) ifb.mem_rdata <= mem_b[ifb.mem_addr];
        if ((ifa.mem_rd && ifa.mem_wr) || (ifb.mem_rd && ifb.mem_wr))
            both_strobe <= both_strobe + 1;
    end

    logic       sel;
    logic       mv, mr, mlast, mdone, mfail, movf, mbusy;
    logic [3:0] mcell;
    int         mlen, mwr;
    logic [15:0] mmem;
    assign mv    = sel ? ifb.path_valid : ifa.path_valid;
    assign mr    = sel ? ifb.path_ready : ifa.path_ready;
    assign mlast = sel ? ifb.path_last  : ifa.path_last;
    assign mcell = sel ? {ifb.path_row, ifb.path_col} : {ifa.path_row, ifa.path_col};
    assign mdone = sel ? done_b : done_a;
    assign mfail = sel ? fail_b : fail_a;
    assign movf  = sel ? ovf_b  : ovf_a;
    assign mbusy = sel ? busy_b : busy_a;
    assign mlen  = sel ? int'(ifb.path_len) : int'(ifa.path_len);
    assign mwr   = sel ? wr_b : wr_a;
    assign mmem  = sel ? mem_b : mem_a;

    int    n_pass = 0, n_total = 0;
    beat_t sbq[$];
    vec_t  vecs[7];

    task automatic check(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic set_ready(input logic r);
        if (sel) ifb.path_ready = r;
        else     ifa.path_ready = r;
    endtask

    task automatic set_start(input logic s);
        if (sel) start_b = s;
        else     start_a = s;
    endtask

    task automatic load_maze(input logic [15:0] walls);
        @(posedge clk); #1;
        if (sel) begin maze_b = walls; load_b = 1'b1; end
        else     begin maze_a = walls; load_a = 1'b1; end
        @(posedge clk); #1;
        load_a = 1'b0;
        load_b = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag, input int stall_after,
                           input int stall_len);
        int    cyc, stalled, beats;
        bit    finished;
        beat_t b, e;
        sel = v.inst;
        load_maze(v.walls);
        sbq.delete();
        for (int i = 0; i < v.n; i++) begin
            b.row  = v.path[63-4*i -: 2];
            b.col  = v.path[61-4*i -: 2];
            b.last = (i == v.n - 1);
            sbq.push_back(b);
        end
        set_ready(1'b1);
        set_start(1'b1);
        cyc = 0; stalled = 0; beats = 0; finished = 0;
        while (!finished && cyc < 2000) begin
            @(posedge clk); #1;
            set_start(1'b0);
            if (stall_len > 0 && beats == stall_after && stalled < stall_len) begin
                set_ready(1'b0);
                stalled++;
            end else begin
                set_ready(1'b1);
            end
            @(negedge clk);
            cyc++;
            if (mv && mr) begin
                if (sbq.size() == 0) begin
                    check({tag, "_extra_beat"}, 1, 0);
                end else begin
                    e = sbq.pop_front();
                    check({tag, "_cell"}, int'(mcell), int'({e.row, e.col}));
                    check({tag, "_last"}, int'(mlast), int'(e.last));
                end
                beats++;
            end else if (!mr && sbq.size() > 0) begin
                check({tag, "_held_valid"}, int'(mv), 1);
                check({tag, "_held_cell"}, int'(mcell), int'({sbq[0].row, sbq[0].col}));
                check({tag, "_held_last"}, int'(mlast), int'(sbq[0].last));
            end
            if (mdone || mfail) finished = 1;
        end
        check({tag, "_finished"}, int'(finished), 1);
        check({tag, "_done"}, int'(mdone), int'(v.exp_done));
        check({tag, "_fail"}, int'(mfail), int'(!v.exp_done));
        check({tag, "_ovf"}, int'(movf), int'(v.exp_ovf));
        check({tag, "_busy"}, int'(mbusy), 0);
        check({tag, "_beats_left"}, sbq.size(), 0);
        check({tag, "_beats_seen"}, beats, v.n);
        if (v.exp_done) check({tag, "_path_len"}, mlen, v.n);
        check({tag, "_mem"}, int'(mmem), int'(v.exp_mem));
        check({tag, "_writes"}, mwr, v.exp_wr);
    endtask

    initial begin
        vecs[0] = '{inst: 0, walls: 16'h0000, n: 7, path: 64'h0123_7BF0_0000_0000,
                    exp_done: 1, exp_ovf: 0, exp_mem: 16'h888F, exp_wr: 7};
        vecs[1] = '{inst: 0, walls: 16'h0224, n: 7, path: 64'h048C_DEF0_0000_0000,
                    exp_done: 1, exp_ovf: 0, exp_mem: 16'hF337, exp_wr: 8};
        vecs[2] = '{inst: 0, walls: 16'h0012, n: 0, path: 64'h0,
                    exp_done: 0, exp_ovf: 0, exp_mem: 16'h0013, exp_wr: 1};
        vecs[3] = '{inst: 0, walls: 16'h0001, n: 0, path: 64'h0,
                    exp_done: 0, exp_ovf: 0, exp_mem: 16'h0001, exp_wr: 0};
        vecs[4] = '{inst: 1, walls: 16'h0000, n: 0, path: 64'h0,
                    exp_done: 0, exp_ovf: 1, exp_mem: 16'h000F, exp_wr: 4};
        vecs[5] = '{inst: 1, walls: 16'h7BDE, n: 4, path: 64'h05AF_0000_0000_0000,
                    exp_done: 1, exp_ovf: 0, exp_mem: 16'hFFFF, exp_wr: 4};
        vecs[6] = '{inst: 0, walls: 16'h0800, n: 9, path: 64'h0123_76AE_F000_0000,
                    exp_done: 1, exp_ovf: 0, exp_mem: 16'hCCCF, exp_wr: 9};

        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; sel = 1'b0;
        load_a = 1'b0; load_b = 1'b0; maze_a = '0; maze_b = '0;
        ifa.path_ready = 1'b1; ifb.path_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", int'(busy_a), 0);
        check("rst_done", int'(done_a), 0);
        check("rst_fail", int'(fail_a), 0);
        check("rst_ovf", int'(ovf_a), 0);
        check("rst_path_valid", int'(ifa.path_valid), 0);
        check("rst_mem_strobes", int'({ifa.mem_rd, ifa.mem_wr}), 0);
        check("rst_path_len", int'(ifa.path_len), 0);
        rst = 1'b0;

        // blocked start cell: read one cycle after sampling, fail two later
        sel = 1'b0;
        load_maze(16'h0001);
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        @(negedge clk);
        check("blk_rd_t1", int'(ifa.mem_rd), 1);
        check("blk_addr_t1", int'(ifa.mem_addr), 0);
        check("blk_busy_t1", int'(busy_a), 1);
        @(negedge clk);
        check("blk_rd_t2", int'(ifa.mem_rd), 0);
        check("blk_fail_t2", int'(fail_a), 0);
        @(negedge clk);
        check("blk_fail_t3", int'(fail_a), 1);
        check("blk_busy_t3", int'(busy_a), 0);
        check("blk_valid_t3", int'(ifa.path_valid), 0);
        check("blk_writes", wr_a, 0);

        for (int i = 0; i < 7; i++)
            run_vec(vecs[i], $sformatf("v%0d", i), 0, 0);

        run_vec(vecs[0], "bp", 3, 5);

        // reset while the path stream is stalled
        sel = 1'b0;
        load_maze(16'h0000);
        ifa.path_ready = 1'b0;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        begin
            int w;
            w = 0;
            while (!ifa.path_valid && w < 200) begin
                @(negedge clk);
                w++;
            end
        end
        check("rstout_reached_out", int'(ifa.path_valid), 1);
        #2 rst = 1'b1;
        #1;
        check("rstout_busy", int'(busy_a), 0);
        check("rstout_done", int'(done_a), 0);
        check("rstout_fail", int'(fail_a), 0);
        check("rstout_valid", int'(ifa.path_valid), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        ifa.path_ready = 1'b1;
        run_vec(vecs[0], "rerun", 0, 0);

        check("single_strobe", both_strobe, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
